// File: rtl/sys_cmd_pkg.sv
// Shared types and constants for the UART command master: FSM states,
// command type encodings and frame header bytes.
package sys_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CMD_RF_WR   = 2'b00,
        CMD_RF_RD   = 2'b01,
        CMD_ALU_OP  = 2'b10,
        CMD_ALU_NOP = 2'b11
    } cmd_type_t;

    localparam logic [7:0] HDR_RF_WR   = 8'hAA;
    localparam logic [7:0] HDR_RF_RD   = 8'hBB;
    localparam logic [7:0] HDR_ALU_OP  = 8'hCC;
    localparam logic [7:0] HDR_ALU_NOP = 8'hDD;

endpackage

// File: rtl/sys_cmd_frame_rom.sv
// Combinational frame table: selects the frame byte at a given index and
// reports the frame length and expected response byte count per command.
module sys_cmd_frame_rom
    import sys_cmd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  cmd_type_t         cmd_type,
    input  logic [1:0]        idx,
    input  logic [3:0]        addr,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [3:0]        fun,
    output logic [WIDTH-1:0]  frame_byte,
    output logic [2:0]        frame_len,
    output logic [1:0]        rsp_cnt
);

    always_comb begin
        frame_byte = '0;
        frame_len  = 3'd1;
        rsp_cnt    = 2'd0;
        unique case (cmd_type)
            CMD_RF_WR: begin
                frame_len = 3'd3;
                rsp_cnt   = 2'd0;
                case (idx)
                    2'd0:    frame_byte = WIDTH'(HDR_RF_WR);
                    2'd1:    frame_byte = WIDTH'(addr);
                    default: frame_byte = a;
                endcase
            end
            CMD_RF_RD: begin
                frame_len = 3'd2;
                rsp_cnt   = 2'd1;
                frame_byte = (idx == 2'd0) ? WIDTH'(HDR_RF_RD) : WIDTH'(addr);
            end
            CMD_ALU_OP: begin
                frame_len = 3'd4;
                rsp_cnt   = 2'd2;
                case (idx)
                    2'd0:    frame_byte = WIDTH'(HDR_ALU_OP);
                    2'd1:    frame_byte = a;
                    2'd2:    frame_byte = b;
                    default: frame_byte = WIDTH'(fun);
                endcase
            end
            CMD_ALU_NOP: begin
                frame_len = 3'd2;
                rsp_cnt   = 2'd2;
                frame_byte = (idx == 2'd0) ? WIDTH'(HDR_ALU_NOP) : WIDTH'(fun);
            end
        endcase
    end

endmodule

// File: rtl/sys_cmd_master.sv
// Command master: serialises a latched command as a UART frame and gathers
// the response bytes. Optional response timeout under SYS_CMD_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | ready for a command
// SEND     | presenting frame bytes to the transmitter
// WAIT_RSP | collecting response bytes from the receiver
// DONE     | one-cycle completion pulse with result
module sys_cmd_master
    import sys_cmd_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_type,
    input  logic [3:0]         cmd_addr,
    input  logic [WIDTH-1:0]   cmd_a,
    input  logic [WIDTH-1:0]   cmd_b,
    input  logic [3:0]         cmd_fun,
    output logic [WIDTH-1:0]   tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    input  logic [WIDTH-1:0]   rx_data,
    input  logic               rx_valid,
    output logic [2*WIDTH-1:0] rsp_data,
    output logic               rsp_valid,
    output logic               rsp_timeout,
    output logic               busy
);

    state_t             state, next_state;
    logic [1:0]         byte_cnt;
    cmd_type_t          typ_q;
    logic [3:0]         addr_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [3:0]         fun_q;
    logic [2*WIDTH-1:0] rsp_buf;
    logic [2*WIDTH-1:0] rsp_next;
    logic [WIDTH-1:0]   frame_byte;
    logic [2:0]         frame_len;
    logic [1:0]         rsp_cnt;
    logic               tx_last;
    logic               rx_last;
    logic               to_expire;

    sys_cmd_frame_rom #(.WIDTH(WIDTH)) u_frame_rom (
        .cmd_type   (typ_q),
        .idx        (byte_cnt),
        .addr       (addr_q),
        .a          (a_q),
        .b          (b_q),
        .fun        (fun_q),
        .frame_byte (frame_byte),
        .frame_len  (frame_len),
        .rsp_cnt    (rsp_cnt)
    );

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign tx_valid  = (state == ST_SEND);
    assign tx_data   = (state == ST_SEND) ? frame_byte : '0;
    assign rsp_valid = (state == ST_DONE);
    assign tx_last   = ({1'b0, byte_cnt} == (frame_len - 3'd1));
    assign rx_last   = (byte_cnt == (rsp_cnt - 2'd1));

`ifdef SYS_CMD_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] to_cnt;

    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign to_expire = (state == ST_WAIT_RSP) && !rx_valid &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt      <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_timeout <= to_expire;
            if (state != ST_WAIT_RSP || rx_valid)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign to_expire          = 1'b0;
    assign rsp_timeout        = 1'b0;
`endif

    always_comb begin
        rsp_next = rsp_buf;
        if (state == ST_WAIT_RSP && rx_valid) begin
            if (byte_cnt[0])
                rsp_next[2*WIDTH-1:WIDTH] = rx_data;
            else
                rsp_next[WIDTH-1:0] = rx_data;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:     if (cmd_valid) next_state = ST_SEND;
            ST_SEND:     if (tx_ready && tx_last)
                             next_state = (rsp_cnt != 2'd0) ? ST_WAIT_RSP : ST_DONE;
            ST_WAIT_RSP: if (rx_valid && rx_last) next_state = ST_DONE;
                         else if (to_expire)      next_state = ST_IDLE;
            ST_DONE:     next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            byte_cnt <= 2'd0;
            typ_q    <= CMD_RF_WR;
            addr_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            fun_q    <= '0;
            rsp_buf  <= '0;
            rsp_data <= '0;
        end else begin
            state   <= next_state;
            rsp_buf <= rsp_next;
            case (state)
                ST_IDLE: if (cmd_valid) begin
                    typ_q    <= cmd_type_t'(cmd_type);
                    addr_q   <= cmd_addr;
                    a_q      <= cmd_a;
                    b_q      <= cmd_b;
                    fun_q    <= cmd_fun;
                    byte_cnt <= 2'd0;
                    rsp_buf  <= '0;
                end
                ST_SEND:     if (tx_ready) byte_cnt <= tx_last ? 2'd0 : byte_cnt + 2'd1;
                ST_WAIT_RSP: if (rx_valid) byte_cnt <= byte_cnt + 2'd1;
                default: ;
            endcase
            // Published result only changes when a command completes.
            if (next_state == ST_DONE)
                rsp_data <= rsp_next;
        end
    end

endmodule
